dbgpwm: RTL
===========

# dbgpwm

Parametrised multi-channel debug waveform generator, successor to the single-channel debug toggle counter. Each of NCH channels produces a programmable low/high waveform with independent period registers, polarity and run mode, free-running or a finite burst. Channels are programmed through a simple register write port and gated by a global enable. The block sits beside the compression unit's debug logic and drives probe/LED pins.

## Interface
- NCH, 4: number of channels (1..16).
- CW, 16: phase counter and period width (1..32).
- BCW, 8: burst count width (1..16).
- clk  in  1  clock; all state changes on its rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- glbl_en_in  in  1  global enable, ANDed with every channel's enable.
- wr_en  in  1  register write strobe, one write per cycle.
- wr_ch  in  max(1,clog2(NCH))  target channel; writes with wr_ch >= NCH are ignored.
- wr_sel  in  2  0 = LO period, 1 = HI period, 2 = CTRL, 3 = ignored.
- wr_data  in  32  write data. Periods use [CW-1:0]. CTRL uses bit0 EN, bit1 BURST, bit2 POL, bits[8+BCW-1:8] BCNT.
- dbg_output  out  NCH  per-channel waveform, registered.
- busy  out  NCH  channel is in LOW or HIGH.
- done  out  NCH  burst complete, sticky.

## Operation
- Per channel: staging registers lo_stg, hi_stg, ctrl. Active registers lo_act, hi_act. A CW-bit counter cnt. States IDLE, LOW, HIGH, DONE.
- Effective enable: en = ctrl.EN && glbl_en_in.
- If en = 0, the channel goes to IDLE on the next edge from any state. cnt is cleared to 0, done is cleared, and no periods are loaded.
- IDLE -> LOW when en = 1: lo_act <= lo_stg, hi_act <= hi_stg, cnt <= 0, and the burst counter is cleared. In BURST mode with BCNT = 0, the channel goes IDLE -> DONE directly.
- LOW: if cnt >= lo_act, go to HIGH with cnt <= 0; otherwise cnt++.
- HIGH: if cnt >= hi_act, go to LOW with cnt <= 0 and reload lo_act/hi_act from staging; otherwise cnt++.
- HIGH in BURST mode: when the end of HIGH is reached and this is the BCNT-th completed high phase, go to DONE instead of LOW.
- Phase lengths: LOW lasts lo_act+1 cycles and HIGH lasts hi_act+1 cycles, so the period is lo+hi+2 cycles. cnt never wraps.
- DONE: done = 1 and the output is idle. The channel leaves DONE only when en drops or CTRL is rewritten; either returns it to IDLE.
- Any CTRL write forces the channel to IDLE on the same edge and clears done. The channel restarts from IDLE on the following edge if en = 1.
- Period writes only update staging and never disturb the current phase.
- If a period write and a reload land on the same edge, the reload takes the pre-write staging value. The new value applies at the next reload.
- dbg_output = (state == HIGH) ^ POL. In IDLE and DONE the output equals POL.
- busy = (state is LOW or HIGH).

## Timing
- Reset (asynchronous, takes effect without a clock edge): all registers are 0, so dbg_output = 0, busy = 0, done = 0.
- If reset asserts mid-operation, all channels abort immediately. After release, channels stay IDLE until CTRL is written.
- A CTRL write with EN = 1 at edge k gives LOW at edge k+1 and the first HIGH at edge k+lo+2.
- All outputs are registered and change only on clk edges, except on reset.
- If glbl_en_in falls, the output reaches its idle value one edge later.
- Channels are fully independent and their outputs are not phase-aligned.

## Configuration
- DBGPWM_BURST_EN defined: BURST mode, the DONE state, the burst counters and the done output are all implemented.
- DBGPWM_BURST_EN undefined: the BURST bit and BCNT are ignored and every channel runs free. done is tied to 0 and no burst counter logic is built.

## Test plan
- Free-run: ch0 LO = 2, HI = 1, EN = 1 -> dbg_output[0] repeats 0,0,0,1,1 (period 5), busy[0] = 1.
- Burst (macro on): ch1 LO = 0, HI = 0, BURST = 1, BCNT = 3 -> pattern 0,1,0,1,0,1, then DONE, dbg_output[1] = 0, done[1] = 1, busy[1] = 0. A CTRL rewrite clears done.
- Shadow update: ch0 running LO = 2, HI = 1. Write HI = 4 during HIGH -> the current HIGH keeps 2 cycles and the following HIGH lasts 5.
- Global gate: drop glbl_en_in mid-HIGH with POL = 1 -> next edge dbg_output = 1, busy = 0. Reassert -> restarts in LOW with cnt = 0.
- Async reset mid-burst: pull rst_l low between edges -> all outputs 0 immediately. CTRL reads back 0 and the channel stays idle after release.
- Edge cases: BURST with BCNT = 0 -> straight to done = 1 with no pulse. A write with wr_ch = NCH or wr_sel = 3 -> no register changes. With the macro off, BURST = 1 runs free.

Source files
------------

// File: rtl/dbgpwm.sv
// rtl/dbgpwm.sv - multi-channel debug waveform generator (burst mode built only with DBGPWM_BURST_EN)
module dbgpwm #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int BCW = 8,
    localparam int WCH = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            glbl_en_in,
    input  logic            wr_en,
    input  logic [WCH-1:0]  wr_ch,
    input  logic [1:0]      wr_sel,
    input  logic [31:0]     wr_data,
    output logic [NCH-1:0]  dbg_output,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Only a subset of the write data is meaningful for any given register.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_e        st_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] lo_stg_q;
        logic [CW-1:0] hi_stg_q;
        logic [CW-1:0] lo_act_q;
        logic [CW-1:0] hi_act_q;
        logic          en_q;
        logic          pol_q;
        logic          out_q;
        logic          busy_q;
        logic          wr_hit;
        logic          ctrl_wr;
        logic          en;
        logic          lo_end;
        logic          hi_end;
        logic          burst_hit;
        logic          burst_zero;

        // Writes addressed beyond NCH never match any channel index.
        assign wr_hit  = wr_en && (wr_ch == WCH'(i));
        assign ctrl_wr = wr_hit && (wr_sel == 2'd2);
        assign en      = en_q && glbl_en_in;
        assign lo_end  = (cnt_q >= lo_act_q);
        assign hi_end  = (cnt_q >= hi_act_q);

`ifdef DBGPWM_BURST_EN
        logic [BCW-1:0] bcnt_q;
        logic [BCW-1:0] bc_q;
        logic           burst_q;
        logic           done_q;

        // bc_q counts completed high phases; the hit fires on the BCNT-th one.
        assign burst_hit  = burst_q &&
                            (({1'b0, bc_q} + {{BCW{1'b0}}, 1'b1}) == {1'b0, bcnt_q});
        assign burst_zero = burst_q && (bcnt_q == '0);

        // Burst configuration, completed-phase counter and sticky done flag
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                bcnt_q  <= '0;
                bc_q    <= '0;
                burst_q <= 1'b0;
                done_q  <= 1'b0;
            end else if (ctrl_wr) begin
                burst_q <= wr_data[1];
                bcnt_q  <= wr_data[8 +: BCW];
                done_q  <= 1'b0;
            end else if (!en) begin
                done_q  <= 1'b0;
            end else if (st_q == S_IDLE) begin
                bc_q    <= '0;
                if (burst_zero) begin
                    done_q <= 1'b1;
                end
            end else if ((st_q == S_HIGH) && hi_end) begin
                if (burst_hit) begin
                    done_q <= 1'b1;
                end else begin
                    bc_q   <= bc_q + BCW'(1);
                end
            end
        end

        assign done[i] = done_q;
`else
        logic [BCW-1:0] unused_bcnt;
        assign unused_bcnt = wr_data[8 +: BCW];
        assign burst_hit   = 1'b0;
        assign burst_zero  = 1'b0;
        assign done[i]     = 1'b0;
`endif

        // Period staging registers; only a reload moves them into the active pair
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                lo_stg_q <= '0;
                hi_stg_q <= '0;
            end else if (wr_hit && (wr_sel == 2'd0)) begin
                lo_stg_q <= wr_data[CW-1:0];
            end else if (wr_hit && (wr_sel == 2'd1)) begin
                hi_stg_q <= wr_data[CW-1:0];
            end
        end

        // Channel FSM with registered waveform and busy outputs
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                st_q     <= S_IDLE;
                cnt_q    <= '0;
                lo_act_q <= '0;
                hi_act_q <= '0;
                en_q     <= 1'b0;
                pol_q    <= 1'b0;
                out_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else if (ctrl_wr) begin
                en_q   <= wr_data[0];
                pol_q  <= wr_data[2];
                st_q   <= S_IDLE;
                cnt_q  <= '0;
                out_q  <= wr_data[2];
                busy_q <= 1'b0;
            end else if (!en) begin
                st_q   <= S_IDLE;
                cnt_q  <= '0;
                out_q  <= pol_q;
                busy_q <= 1'b0;
            end else begin
                case (st_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        out_q <= pol_q;
                        if (burst_zero) begin
                            st_q   <= S_DONE;
                            busy_q <= 1'b0;
                        end else begin
                            st_q     <= S_LOW;
                            lo_act_q <= lo_stg_q;
                            hi_act_q <= hi_stg_q;
                            busy_q   <= 1'b1;
                        end
                    end
                    S_LOW: begin
                        if (lo_end) begin
                            st_q  <= S_HIGH;
                            cnt_q <= '0;
                            out_q <= ~pol_q;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_HIGH: begin
                        if (hi_end) begin
                            cnt_q <= '0;
                            out_q <= pol_q;
                            if (burst_hit) begin
                                st_q   <= S_DONE;
                                busy_q <= 1'b0;
                            end else begin
                                st_q     <= S_LOW;
                                lo_act_q <= lo_stg_q;
                                hi_act_q <= hi_stg_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_DONE: begin
                        out_q  <= pol_q;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        st_q   <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign dbg_output[i] = out_q;
        assign busy[i]       = busy_q;
    end

endmodule
